fancy_timer_param: RTL and testbench
====================================

// Module: fancy_timer_param
//
// PURPOSE
//   Parametrised pattern-triggered delay timer. Watches a serial data stream
//   for a configurable start pattern, then shifts in a DLY_W-bit delay value,
//   MSB first. It then counts for (delay+1)*TICK clock cycles, flags done and
//   waits for an acknowledge. Generalises the fixed 1101/4-bit/1000-cycle timer.
//   Adds an abort path and a defined count value outside counting.
//
// PARAMETERS
//   PAT_W    4        start-pattern length in bits (>=1)
//   PATTERN  4'b1101  start pattern; bit PAT_W-1 is the first bit received
//   DLY_W    4        delay field width in bits (>=1)
//   TICK     1000     clock cycles per delay unit (>=2)
//
// PORTS
//   clk       in   1      clock; all state updates on rising edge
//   areset_n  in   1      asynchronous active-low reset
//   data      in   1      serial input, sampled every clock
//   ack       in   1      acknowledge; sampled only in WAIT
//   abort     in   1      cancel; sampled in SHIFT, COUNT, WAIT
//   count     out  DLY_W  remaining delay units while counting, else 0
//   counting  out  1      high while in COUNT
//   done      out  1      high while in WAIT
//
// BEHAVIOUR
//   - Reset (areset_n=0, asynchronous, any time): state=SEARCH, pattern history
//     cleared (0 valid bits), delay reg=0, tick counter=0.
//     Outputs: count=0, counting=0, done=0.
//   - Outputs are Moore, decoded from registered state; no combinational path
//     from any input to any output.
//   - SEARCH: keep the last PAT_W samples plus a valid-bit count saturating at
//     PAT_W. A match requires a full history equal to PATTERN. Overlapping
//     matches are allowed, e.g. 1,1,1,0,1 matches 1101. On the edge that samples
//     the last pattern bit, go to SHIFT.
//   - SHIFT: exactly DLY_W cycles. Each edge shifts data into the delay reg LSB,
//     so the first bit ends up as MSB. On the edge that samples the last delay
//     bit, go to COUNT with tick=0 and count=delay.
//   - COUNT: tick increments every cycle and wraps TICK-1 -> 0.
//     - When tick==TICK-1 and count!=0: count decrements.
//     - When tick==TICK-1 and count==0: go to WAIT.
//     - counting stays high for exactly (delay+1)*TICK cycles. delay=0 gives
//       TICK cycles; all-ones gives 2^DLY_W*TICK cycles.
//     - data is ignored in COUNT and WAIT; patterns inside them never trigger.
//   - WAIT: done=1 until ack=1 or abort=1 is sampled, then go to SEARCH. If ack
//     is high on WAIT entry, WAIT lasts exactly 1 cycle.
//   - abort=1 in SHIFT or COUNT: go to SEARCH on the next edge. Delay reg and
//     tick are cleared; count and counting are 0 from that edge. abort beats
//     the COUNT->WAIT transition on the same edge.
//   - Every entry to SEARCH (ack, abort) clears the pattern history. Bits sampled
//     in earlier states never contribute to a match. The first possible match is
//     PAT_W cycles after entry.
//   - Widths: tick counter is $clog2(TICK) bits. All compares are against the
//     full-width constant TICK-1. count never wraps below 0.
//
// TESTING
//   1. Defaults. data=1,1,0,1 then 0,1,0,1 -> counting rises the edge after the
//      last delay bit and holds 6000 cycles. count reads 5,4,3,2,1,0, each for
//      1000 cycles. Then done=1 until ack; ack -> SEARCH, done=0.
//   2. Overlap and false starts. data=1,1,1,0,1,0,0,0,0 -> match on the 5th bit,
//      delay=0, counting exactly 1000 cycles. data=1,0,1,1,0 -> no match.
//   3. Abort at count=3, tick=500 -> next edge counting=0, count=0, done never
//      asserts. A fresh 1101 is needed, and data before the abort is ignored.
//   4. Async reset. Drop areset_n mid-SHIFT and mid-COUNT (between clock edges)
//      -> outputs go to 0 immediately. After release, behaves as test 1.
//   5. Overrides PAT_W=3, PATTERN=3'b101, DLY_W=2, TICK=4. data=1,0,1,1,1 ->
//      delay=3, counting 16 cycles, count 3->0 every 4 cycles, then done.
//   6. Ack held high entering WAIT -> done high 1 cycle. 1101 sent during COUNT
//      and WAIT -> no retrigger. After ack, 1101 restarts normally.

Source files
------------

// File: rtl/fancy_timer_param_if.sv
// Serial control/status bundle for the pattern-triggered delay timer.
// Latency: none, plain wires.
// Backpressure: none; ack/abort are level inputs sampled by the timer.
interface fancy_timer_param_if #(
    parameter int DLY_W = 4
);
    logic             data;
    logic             ack;
    logic             abort;
    logic [DLY_W-1:0] count;
    logic             counting;
    logic             done;

    // Driver side: stimulus out, status in.
    modport master (
        output data,
        output ack,
        output abort,
        input  count,
        input  counting,
        input  done
    );

    // Timer side: stimulus in, status out.
    modport slave (
        input  data,
        input  ack,
        input  abort,
        output count,
        output counting,
        output done
    );
endinterface

// File: rtl/fancy_timer_param.sv
// Pattern-triggered delay timer: match PATTERN, shift DLY_W delay bits, count (delay+1)*TICK cycles.
// Latency: counting rises the edge after the last delay bit; outputs are Moore (registered state only).
// Backpressure: done holds until ack or abort is sampled; abort cancels SHIFT/COUNT/WAIT next edge.
module fancy_timer_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               DLY_W   = 4,
    parameter int               TICK    = 1000
) (
    input  logic                clk,
    input  logic                areset_n,
    fancy_timer_param_if.slave  bus
);

    localparam int TW = $clog2(TICK);
    localparam int VW = $clog2(PAT_W + 1);
    localparam int BW = (DLY_W > 1) ? $clog2(DLY_W) : 1;

    localparam logic [TW-1:0] TICK_MAX = TW'(TICK - 1);
    localparam logic [VW-1:0] VCNT_MAX = VW'(PAT_W);
    localparam logic [BW-1:0] BCNT_MAX = BW'(DLY_W - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COUNT  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q,  hist_d;
    logic [VW-1:0]    vcnt_q,  vcnt_d;
    logic [DLY_W-1:0] dly_q,   dly_d;
    logic [BW-1:0]    bcnt_q,  bcnt_d;
    logic [TW-1:0]    tick_q,  tick_d;

    logic [PAT_W:0]   hist_ext;
    logic [DLY_W:0]   dly_ext;

    // Shifted views so the newest sample always lands in the LSB.
    assign hist_ext = {hist_q, bus.data};
    assign dly_ext  = {dly_q, bus.data};

    // State register and datapath flops; reset returns to an empty search.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_SEARCH;
            hist_q  <= '0;
            vcnt_q  <= '0;
            dly_q   <= '0;
            bcnt_q  <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            vcnt_q  <= vcnt_d;
            dly_q   <= dly_d;
            bcnt_q  <= bcnt_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic; any return to SEARCH wipes history, delay and tick.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        vcnt_d  = vcnt_q;
        dly_d   = dly_q;
        bcnt_d  = bcnt_q;
        tick_d  = tick_q;

        case (state_q)
            ST_SEARCH: begin
                hist_d = hist_ext[PAT_W-1:0];
                vcnt_d = (vcnt_q == VCNT_MAX) ? vcnt_q : vcnt_q + VW'(1);
                // Only a full window of fresh samples may match.
                if ((vcnt_d == VCNT_MAX) && (hist_d == PATTERN)) begin
                    state_d = ST_SHIFT;
                    hist_d  = '0;
                    vcnt_d  = '0;
                    dly_d   = '0;
                    bcnt_d  = '0;
                end
            end

            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d = ST_SEARCH;
                    dly_d   = '0;
                    bcnt_d  = '0;
                    tick_d  = '0;
                end else begin
                    dly_d = dly_ext[DLY_W-1:0];
                    if (bcnt_q == BCNT_MAX) begin
                        state_d = ST_COUNT;
                        bcnt_d  = '0;
                        tick_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end

            ST_COUNT: begin
                // abort takes priority over the final-tick move to WAIT.
                if (bus.abort) begin
                    state_d = ST_SEARCH;
                    dly_d   = '0;
                    tick_d  = '0;
                end else if (tick_q == TICK_MAX) begin
                    tick_d = '0;
                    if (dly_q != '0) begin
                        dly_d = dly_q - DLY_W'(1);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            ST_WAIT: begin
                if (bus.ack || bus.abort) begin
                    state_d = ST_SEARCH;
                    hist_d  = '0;
                    vcnt_d  = '0;
                    dly_d   = '0;
                    tick_d  = '0;
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // Moore outputs; count reads 0 whenever the timer is not counting.
    assign bus.counting = (state_q == ST_COUNT);
    assign bus.done     = (state_q == ST_WAIT);
    assign bus.count    = (state_q == ST_COUNT) ? dly_q : '0;

endmodule

// File: tb/tb_fancy_timer_param.sv
// Bench for fancy_timer_param: default instance plus a small-parameter instance.
// Latency: each step drives at negedge, samples 1ns after the following posedge.
// Backpressure: ack/abort driven directly by the stimulus tasks.
module tb_fancy_timer_param;

    logic clk = 1'b0;
    logic areset_n = 1'b1;

    always #5 clk = ~clk;

    fancy_timer_param_if #(.DLY_W(4)) ifa ();
    fancy_timer_param_if #(.DLY_W(2)) ifb ();

    fancy_timer_param dut_a (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (ifa)
    );

    fancy_timer_param #(
        .PAT_W   (3),
        .PATTERN (3'b101),
        .DLY_W   (2),
        .TICK    (4)
    ) dut_b (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (ifb)
    );

    typedef struct {
        string nm;
        logic  c;
        logic  dn;
        int    cnt;
    } exp_t;

    typedef struct {
        logic d;
        logic a;
        logic ab;
        logic c;
        logic dn;
        int   cnt;
    } vec_t;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(int sel, string nm, logic d, logic a, logic ab,
                        logic ec, logic ed, int ecnt);
        exp_t e;
        e.nm = nm; e.c = ec; e.dn = ed; e.cnt = ecnt;
        sb.push_back(e);
        @(negedge clk);
        if (sel == 0) begin
            ifa.data = d; ifa.ack = a; ifa.abort = ab;
        end else begin
            ifb.data = d; ifb.ack = a; ifb.abort = ab;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (sel == 0) begin
            check({e.nm, ".counting"}, 32'(ifa.counting), 32'(e.c));
            check({e.nm, ".done"},     32'(ifa.done),     32'(e.dn));
            check({e.nm, ".count"},    32'(ifa.count),    32'(e.cnt));
        end else begin
            check({e.nm, ".counting"}, 32'(ifb.counting), 32'(e.c));
            check({e.nm, ".done"},     32'(ifb.done),     32'(e.dn));
            check({e.nm, ".count"},    32'(ifb.count),    32'(e.cnt));
        end
    endtask

    // Remaining COUNT cycles after the entry edge, then the WAIT entry edge.
    // data cycles through 1101 to show patterns are ignored while counting.
    task automatic run_count(int sel, int d, int t, logic a);
        logic [3:0] p;
        p = 4'b1101;
        for (int k = 1; k < (d + 1) * t; k++) begin
            step(sel, "count", p[3 - (k % 4)], a, 1'b0, 1'b1, 1'b0, d - k / t);
        end
        step(sel, "wait_entry", 1'b0, a, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic send_idle(int sel, string nm, logic [7:0] bits, int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(sel, nm, bits[i], 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic check_zero(string nm);
        check({nm, ".counting"}, 32'(ifa.counting), 32'd0);
        check({nm, ".done"},     32'(ifa.done),     32'd0);
        check({nm, ".count"},    32'(ifa.count),    32'd0);
    endtask

    vec_t tv[18];

    initial begin
        ifa.data = 1'b0; ifa.ack = 1'b0; ifa.abort = 1'b0;
        ifb.data = 1'b0; ifb.ack = 1'b0; ifb.abort = 1'b0;

        // Reset state.
        #2 areset_n = 1'b0;
        #1;
        check_zero("reset_a");
        check("reset_b.counting", 32'(ifb.counting), 32'd0);
        check("reset_b.done",     32'(ifb.done),     32'd0);
        @(negedge clk);
        @(negedge clk);
        areset_n = 1'b1;

        // Test 1: 1101 then delay 0101 -> 6000 counting cycles, then done until ack.
        send_idle(0, "t1_pat", 8'b1101, 4);
        send_idle(0, "t1_dly", 8'b010, 3);
        step(0, "t1_enter", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        run_count(0, 5, 1000, 1'b0);
        // 1101 during WAIT does nothing; done holds.
        step(0, "t1_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(0, "t1_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(0, "t1_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(0, "t1_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(0, "t1_ack",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        // These would complete 1101 only if WAIT-era bits were kept.
        send_idle(0, "t1_hist", 8'b1010000, 7);

        // Test 2: false start, overlap match, delay 0.
        tv = '{
            '{1,0,0,0,0,0}, '{0,0,0,0,0,0}, '{1,0,0,0,0,0}, '{1,0,0,0,0,0},
            '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, '{0,0,0,0,0,0},
            '{0,0,0,0,0,0}, '{1,0,0,0,0,0}, '{1,0,0,0,0,0}, '{1,0,0,0,0,0},
            '{0,0,0,0,0,0}, '{1,0,0,0,0,0}, '{0,0,0,0,0,0}, '{0,0,0,0,0,0},
            '{0,0,0,0,0,0}, '{0,0,0,1,0,0}
        };
        for (int i = 0; i < 18; i++) begin
            step(0, $sformatf("t2_vec%0d", i), tv[i].d, tv[i].a, tv[i].ab,
                 tv[i].c, tv[i].dn, tv[i].cnt);
        end
        // Test 6 part: ack held high through COUNT into WAIT -> one-cycle done.
        run_count(0, 0, 1000, 1'b1);
        step(0, "t6_ack_held", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Test 3: abort at count=3, tick=500.
        send_idle(0, "t3_pat", 8'b1101, 4);
        send_idle(0, "t3_dly", 8'b001, 3);
        step(0, "t3_enter", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        for (int k = 1; k <= 500; k++) begin
            step(0, "t3_count", k[0], 1'b0, 1'b0, 1'b1, 1'b0, 3);
        end
        step(0, "t3_abort", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_idle(0, "t3_after", 8'b1010000, 7);
        // Abort during SHIFT.
        send_idle(0, "t3s_pat", 8'b11011, 5);
        step(0, "t3s_abort", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_idle(0, "t3s_after", 8'b0000, 4);

        // Test 4: async reset mid-SHIFT and mid-COUNT.
        send_idle(0, "t4_pat", 8'b11010, 5);
        @(negedge clk);
        #2 areset_n = 1'b0;
        #1 check_zero("t4_rst_shift");
        @(negedge clk);
        areset_n = 1'b1;
        send_idle(0, "t4_post_shift", 8'b000, 3);
        send_idle(0, "t4_pat2", 8'b1101001, 7);
        step(0, "t4_enter", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        for (int k = 1; k <= 10; k++) begin
            step(0, "t4_count", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        end
        @(negedge clk);
        #2 areset_n = 1'b0;
        #1 check_zero("t4_rst_count");
        @(posedge clk);
        #1 check_zero("t4_rst_held");
        @(negedge clk);
        areset_n = 1'b1;
        send_idle(0, "t4_re_pat", 8'b1101000, 7);
        step(0, "t4_re_enter", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        run_count(0, 1, 1000, 1'b0);
        step(0, "t4_ack", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Test 5: PAT_W=3, 101, DLY_W=2, TICK=4; data 1,0,1,1,1 -> delay 3.
        send_idle(1, "t5_pat", 8'b1011, 4);
        step(1, "t5_enter", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        run_count(1, 3, 4, 1'b0);
        step(1, "t5_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step(1, "t5_abort_wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        // Abort on the final tick beats COUNT->WAIT.
        send_idle(1, "t5b_pat", 8'b1010, 4);
        step(1, "t5b_enter", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 1; k <= 3; k++) begin
            step(1, "t5b_count", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        end
        step(1, "t5b_abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step(1, "t5b_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
